mem1p_ctrl: RTL

- Access controller that sits directly upstream of the single-port RAM macro (two-cycle registered read: internal read register, then output register).
- Accepts independent write and read-request streams with valid/ready handshakes.
- Arbitrates them onto the single RAM port (addr/din/me/wnr).
- Returns read data on a valid/ready response stream through a credit-protected response buffer, so downstream backpressure never loses RAM output.

---
 rtl/mem1p_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem1p_ctrl.sv
// Single-port RAM access controller: write/read arbitration plus a credit-protected response FIFO.
// Optional macro MEM1P_CTRL_WPRI_EN selects fixed write priority instead of round-robin.
module mem1p_ctrl #(
  parameter int unsigned   DEPTH      = 2048,
  parameter int unsigned   WIDTH      = 24,
  parameter int unsigned   RBUF_DEPTH = 4,
  localparam int unsigned  A          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [A-1:0]     wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rq_valid,
  output logic             rq_ready,
  input  logic [A-1:0]     rq_addr,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [A-1:0]     mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_me,
  output logic             mem_wnr,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam int unsigned CW = $clog2(RBUF_DEPTH + 1);
  localparam int unsigned PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

  logic [1:0]       issue_sr_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [WIDTH-1:0] rbuf_q [RBUF_DEPTH];
  logic             read_ok, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts reads still in the RAM pipeline; uses registered count only so
  // a pop never feeds back combinationally into rq_ready.
  assign read_ok = (32'(count_q) + 32'(issue_sr_q[0]) + 32'(issue_sr_q[1])) < RBUF_DEPTH;

`ifdef MEM1P_CTRL_WPRI_EN
  always_comb begin
    wr_ready = 1'b0;
    rq_ready = 1'b0;
    if (rst_n) begin
      wr_ready = wr_valid;
      rq_ready = !wr_valid && rq_valid && read_ok;
    end
  end
`else
  logic last_rd_q;  // 1 = last grant went to the read channel

  always_comb begin
    wr_ready = 1'b0;
    rq_ready = 1'b0;
    if (rst_n) begin
      if (wr_valid && rq_valid && read_ok) begin
        wr_ready = last_rd_q;
        rq_ready = !last_rd_q;
      end else begin
        wr_ready = wr_valid;
        rq_ready = !wr_valid && rq_valid && read_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q <= 1'b1;
    end else if (wr_ready || rq_ready) begin
      last_rd_q <= rq_ready;
    end
  end
`endif

  assign mem_me   = wr_ready | rq_ready;
  assign mem_wnr  = wr_ready;
  assign mem_addr = wr_ready ? wr_addr : (rq_ready ? rq_addr : '0);
  assign mem_din  = wr_ready ? wr_data : '0;

  // issue_sr_q[1] marks the cycle in which the RAM output register holds that read's data.
  assign push     = issue_sr_q[1];
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? rbuf_q[head_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_sr_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      issue_sr_q <= {issue_sr_q[0], rq_ready};
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) rbuf_q[tail_q] <= mem_dout;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (32'(count_q) == RBUF_DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n) !(wr_ready && rq_ready));

endmodule
